// File: rtl/ecc_scrubber_if.sv
// Memory-arbiter port of the ECC scrubber: one request/grant channel carrying
// 16-bit SECDED codewords (bit 16 = overall parity).
interface ecc_scrubber_if #(
   parameter int ADDR_W = 8
);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [16:1]       mem_wdata;
   logic              mem_gnt;
   logic [16:1]       mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_gnt, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_gnt, mem_rdata
   );
endinterface

// File: rtl/ecc_scrubber.sv
// Background SECDED scrubber: paces through every address, corrects single-bit
// errors by write-back and counts/reports double-bit errors.

module hamming_decoder (
   input  logic [16:1] cw,
   output logic        error,
   output logic        uncorrectable,
   output logic [3:0]  error_index
);
   logic [3:0] syn;
   logic       par;

   always_comb begin
      syn = '0;
      for (int i = 1; i <= 15; i++) begin
         if (cw[i]) syn = syn ^ 4'(i);
      end
   end

   // A lone bit-16 flip leaves the syndrome at 0 and is deliberately ignored.
   assign par           = ^cw;
   assign error         = (syn != 4'd0);
   assign uncorrectable = error && !par;
   assign error_index   = syn;
endmodule

// state    | meaning
// S_IDLE   | scrubbing disabled, waiting for enable
// S_WAIT   | pacing interval down-count
// S_RD_REQ | read request held until grant
// S_RD_DATA| capture read codeword into cw
// S_CHECK  | evaluate decoder on cw, update counters
// S_WR_REQ | corrected write-back held until grant
// S_NEXT   | advance address, flag pass wrap
module ecc_scrubber #(
   parameter int ADDR_W   = 8,
   parameter int DEPTH    = 256,
   parameter int INTERVAL = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              clr_counts,
   ecc_scrubber_if.master    bus,
   output logic              busy,
   output logic [15:0]       corr_count,
   output logic [15:0]       uncorr_count,
   output logic [ADDR_W-1:0] last_uncorr_addr,
   output logic              uncorr_irq,
   output logic              pass_done
);
   localparam int CNT_W = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(INTERVAL - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_RD_REQ, S_RD_DATA, S_CHECK, S_WR_REQ, S_NEXT
   } state_t;

   state_t           state, state_nxt;
   logic             load_wait;
   logic [CNT_W-1:0] wait_cnt;
   logic [16:1]      cw;
   logic [16:1]      cw_fixed;
   logic             dec_error, dec_uncorr;
   logic [3:0]       dec_index;
   logic             do_corr, do_uncorr;

   hamming_decoder u_dec (
      .cw            (cw),
      .error         (dec_error),
      .uncorrectable (dec_uncorr),
      .error_index   (dec_index)
   );

   always_comb begin
      cw_fixed = cw;
      for (int i = 1; i <= 15; i++) begin
         if (dec_index == 4'(i)) cw_fixed[i] = ~cw[i];
      end
   end

   assign do_corr   = (state == S_CHECK) && dec_error && !dec_uncorr;
   assign do_uncorr = (state == S_CHECK) && dec_uncorr;

   always_comb begin
      state_nxt = state;
      load_wait = 1'b0;
      case (state)
         S_IDLE:    if (enable) begin
                       state_nxt = S_WAIT;
                       load_wait = 1'b1;
                    end
         S_WAIT:    if (wait_cnt == '0) state_nxt = S_RD_REQ;
         S_RD_REQ:  if (bus.mem_gnt) state_nxt = S_RD_DATA;
         S_RD_DATA: state_nxt = S_CHECK;
         S_CHECK:   state_nxt = do_corr ? S_WR_REQ : S_NEXT;
         S_WR_REQ:  if (bus.mem_gnt) state_nxt = S_NEXT;
         S_NEXT:    if (enable) begin
                       state_nxt = S_WAIT;
                       load_wait = 1'b1;
                    end else begin
                       state_nxt = S_IDLE;
                    end
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         wait_cnt      <= '0;
         cw            <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         busy          <= 1'b0;
         pass_done     <= 1'b0;
         uncorr_irq    <= 1'b0;
      end else begin
         state <= state_nxt;

         if (load_wait)
            wait_cnt <= CNT_LOAD;
         else if (state == S_WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - 1'b1;

         if (state == S_RD_DATA) cw <= bus.mem_rdata;

         // Request flags follow the next state so they are registered yet
         // aligned with the RD_REQ/WR_REQ cycles.
         bus.mem_req <= (state_nxt == S_RD_REQ) || (state_nxt == S_WR_REQ);
         bus.mem_we  <= (state_nxt == S_WR_REQ);

         if (do_corr) bus.mem_wdata <= cw_fixed;

         if (state == S_NEXT)
            bus.mem_addr <= (bus.mem_addr == LAST_ADDR) ? '0 : bus.mem_addr + 1'b1;

         busy       <= (state_nxt != S_IDLE);
         pass_done  <= (state == S_NEXT) && (bus.mem_addr == LAST_ADDR);
         uncorr_irq <= do_uncorr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         corr_count       <= '0;
         uncorr_count     <= '0;
         last_uncorr_addr <= '0;
      end else begin
         if (clr_counts) begin
            corr_count   <= '0;
            uncorr_count <= '0;
         end else begin
            if (do_corr && corr_count != 16'hFFFF)
               corr_count <= corr_count + 16'd1;
            if (do_uncorr && uncorr_count != 16'hFFFF)
               uncorr_count <= uncorr_count + 16'd1;
         end
         if (do_uncorr) last_uncorr_addr <= bus.mem_addr;
      end
   end
endmodule

// File: tb/tb_ecc_scrubber.sv
// Directed bench for ecc_scrubber: DEPTH=4, INTERVAL=2, hand-built codewords in a
// small memory model with controllable grant.
module tb_ecc_scrubber;
   localparam int ADDR_W = 8;

   // Valid codewords ({6,5,3}, {15,11,10,9,7}, all ones) and hand-made corruptions.
   localparam logic [16:1] CW_A      = 16'h8034;
   localparam logic [16:1] CW_B      = 16'hC740;
   localparam logic [16:1] CW_ONES   = 16'hFFFF;
   localparam logic [16:1] CW_A_B5   = 16'h8024;
   localparam logic [16:1] CW_B_B3B9 = 16'hC644;
   localparam logic [16:1] CW_A_B16  = 16'h0034;
   localparam logic [16:1] CW_B_B1   = 16'hC741;
   localparam logic [16:1] CW_1_B10  = 16'hFDFF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic enable = 1'b0;
   logic clr_counts = 1'b0;
   logic gnt_en = 1'b1;
   logic busy, uncorr_irq, pass_done;
   logic [15:0] corr_count, uncorr_count;
   logic [ADDR_W-1:0] last_uncorr_addr;
   logic [16:1] rdata_q = '0;
   logic [16:1] mem [0:255];

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;

   logic [ADDR_W-1:0] rd_addr_q[$];
   int                rd_cyc_q[$];
   logic [ADDR_W-1:0] wr_addr_q[$];
   logic [16:1]       wr_data_q[$];
   int irq_cnt, irq_cyc, pass_cnt, pass_cyc;

   ecc_scrubber_if #(.ADDR_W(ADDR_W)) bus ();

   assign bus.mem_gnt   = gnt_en;
   assign bus.mem_rdata = rdata_q;

   ecc_scrubber #(.ADDR_W(ADDR_W), .DEPTH(4), .INTERVAL(2)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .enable           (enable),
      .clr_counts       (clr_counts),
      .bus              (bus.master),
      .busy             (busy),
      .corr_count       (corr_count),
      .uncorr_count     (uncorr_count),
      .last_uncorr_addr (last_uncorr_addr),
      .uncorr_irq       (uncorr_irq),
      .pass_done        (pass_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory model: read data appears the cycle after the read grant.
   always @(posedge clk) begin
      if (bus.mem_req && bus.mem_gnt) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            rdata_q <= mem[bus.mem_addr];
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.mem_req && bus.mem_gnt) begin
            if (bus.mem_we) begin
               wr_addr_q.push_back(bus.mem_addr);
               wr_data_q.push_back(bus.mem_wdata);
            end else begin
               rd_addr_q.push_back(bus.mem_addr);
               rd_cyc_q.push_back(cyc);
            end
         end
         if (uncorr_irq) begin
            irq_cnt++;
            irq_cyc = cyc;
         end
         if (pass_done) begin
            pass_cnt++;
            pass_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      rd_addr_q.delete();
      rd_cyc_q.delete();
      wr_addr_q.delete();
      wr_data_q.delete();
      irq_cnt = 0;
      irq_cyc = 0;
      pass_cnt = 0;
      pass_cyc = 0;
   endtask

   task automatic init_mem();
      mem[0] = CW_A;
      mem[1] = CW_B;
      mem[2] = CW_A;
      mem[3] = CW_ONES;
   endtask

   task automatic apply_reset();
      enable = 1'b0;
      clr_counts = 1'b0;
      gnt_en = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      init_mem();
      clear_logs();
      tick();
   endtask

   task automatic wait_reads(input int n, input int bound, output bit ok);
      for (int k = 0; k < bound && rd_addr_q.size() < n; k++) tick();
      ok = (rd_addr_q.size() >= n);
   endtask

   task automatic wait_writes(input int n, input int bound, output bit ok);
      for (int k = 0; k < bound && wr_addr_q.size() < n; k++) tick();
      ok = (wr_addr_q.size() >= n);
   endtask

   task automatic stop_scrub();
      enable = 1'b0;
      for (int k = 0; k < 50 && busy; k++) tick();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      enable = 1'b1;
      tick();
      tick();
      n_checks++;
      if ({bus.mem_req, bus.mem_we, busy, uncorr_irq, pass_done} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_flags: req/we/busy/irq/pass = %b, expected 00000",
                  {bus.mem_req, bus.mem_we, busy, uncorr_irq, pass_done});
      end
      n_checks++;
      if (bus.mem_addr !== 8'd0 || bus.mem_wdata !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_bus: addr=%0h wdata=%0h, expected 0/0", bus.mem_addr, bus.mem_wdata);
      end
      n_checks++;
      if (corr_count !== 16'h0 || uncorr_count !== 16'h0 || last_uncorr_addr !== 8'h0) begin
         n_fail++;
         $display("FAIL reset_counts: corr=%0h uncorr=%0h last=%0h, expected 0/0/0",
                  corr_count, uncorr_count, last_uncorr_addr);
      end
      enable = 1'b0;
   endtask

   task automatic test_clean_pass();
      bit ok;
      apply_reset();
      enable = 1'b1;
      wait_reads(5, 200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL clean_reads: got %0d reads, expected 5", rd_addr_q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rd_addr_q[i] !== 8'((i == 4) ? 0 : i)) begin
               n_fail++;
               $display("FAIL clean_addr[%0d]: got %0d expected %0d", i, rd_addr_q[i], (i == 4) ? 0 : i);
            end
         end
         for (int i = 1; i < 5; i++) begin
            n_checks++;
            if (rd_cyc_q[i] - rd_cyc_q[i-1] !== 6) begin
               n_fail++;
               $display("FAIL clean_spacing[%0d]: got %0d cycles expected 6", i, rd_cyc_q[i] - rd_cyc_q[i-1]);
            end
         end
         n_checks++;
         if (pass_cnt !== 1 || pass_cyc - rd_cyc_q[3] !== 4) begin
            n_fail++;
            $display("FAIL clean_pass_done: count=%0d offset=%0d, expected 1 and 4",
                     pass_cnt, pass_cyc - rd_cyc_q[3]);
         end
      end
      n_checks++;
      if (wr_addr_q.size() !== 0 || corr_count !== 16'h0 || uncorr_count !== 16'h0) begin
         n_fail++;
         $display("FAIL clean_nowrite: writes=%0d corr=%0d uncorr=%0d, expected 0/0/0",
                  wr_addr_q.size(), corr_count, uncorr_count);
      end
      stop_scrub();
   endtask

   task automatic test_correct();
      bit ok;
      apply_reset();
      mem[2] = CW_A_B5;
      enable = 1'b1;
      wait_writes(1, 200, ok);
      n_checks++;
      if (!ok || wr_addr_q[0] !== 8'd2 || wr_data_q[0] !== CW_A) begin
         n_fail++;
         $display("FAIL correct_write: ok=%0d addr=%0d data=%0h, expected addr 2 data %0h",
                  ok, ok ? wr_addr_q[0] : 8'hxx, ok ? wr_data_q[0] : 16'hxxxx, CW_A);
      end
      n_checks++;
      if (corr_count !== 16'd1 || uncorr_count !== 16'd0) begin
         n_fail++;
         $display("FAIL correct_counts: corr=%0d uncorr=%0d, expected 1/0", corr_count, uncorr_count);
      end
      wait_reads(4, 100, ok);
      n_checks++;
      if (!ok || rd_cyc_q[3] - rd_cyc_q[2] !== 7 || mem[2] !== CW_A) begin
         n_fail++;
         $display("FAIL correct_timing: ok=%0d word cycles=%0d mem2=%0h, expected 7 and %0h",
                  ok, ok ? rd_cyc_q[3] - rd_cyc_q[2] : -1, mem[2], CW_A);
      end
      stop_scrub();
   endtask

   task automatic test_uncorrectable();
      bit ok;
      apply_reset();
      mem[1] = CW_B_B3B9;
      enable = 1'b1;
      wait_reads(3, 200, ok);
      n_checks++;
      if (!ok || irq_cnt !== 1 || irq_cyc - rd_cyc_q[1] !== 3) begin
         n_fail++;
         $display("FAIL uncorr_irq: ok=%0d high cycles=%0d offset=%0d, expected 1 cycle at offset 3",
                  ok, irq_cnt, ok ? irq_cyc - rd_cyc_q[1] : -1);
      end
      n_checks++;
      if (uncorr_count !== 16'd1 || last_uncorr_addr !== 8'd1 || corr_count !== 16'd0) begin
         n_fail++;
         $display("FAIL uncorr_counts: uncorr=%0d last=%0d corr=%0d, expected 1/1/0",
                  uncorr_count, last_uncorr_addr, corr_count);
      end
      n_checks++;
      if (wr_addr_q.size() !== 0 || mem[1] !== CW_B_B3B9) begin
         n_fail++;
         $display("FAIL uncorr_nowrite: writes=%0d mem1=%0h, expected 0 and %0h",
                  wr_addr_q.size(), mem[1], CW_B_B3B9);
      end
      stop_scrub();
   endtask

   task automatic test_bit16_only();
      bit ok;
      apply_reset();
      mem[0] = CW_A_B16;
      enable = 1'b1;
      wait_reads(2, 100, ok);
      n_checks++;
      if (!ok || wr_addr_q.size() !== 0 || corr_count !== 16'd0 || uncorr_count !== 16'd0 || irq_cnt !== 0) begin
         n_fail++;
         $display("FAIL bit16_ignored: ok=%0d writes=%0d corr=%0d uncorr=%0d irq=%0d, expected all 0",
                  ok, wr_addr_q.size(), corr_count, uncorr_count, irq_cnt);
      end
      stop_scrub();
   endtask

   task automatic test_stall_write();
      bit ok;
      int k;
      apply_reset();
      mem[2] = CW_A_B5;
      enable = 1'b1;
      wait_reads(3, 200, ok);
      gnt_en = 1'b0;
      for (k = 0; k < 10 && !bus.mem_req; k++) tick();
      n_checks++;
      if (!ok || !bus.mem_req) begin
         n_fail++;
         $display("FAIL stall_reach_wr: ok=%0d req=%0b, expected write request", ok, bus.mem_req);
      end
      for (int i = 0; i < 7; i++) begin
         if (i == 2) enable = 1'b0;
         n_checks++;
         if ({bus.mem_req, bus.mem_we} !== 2'b11 || bus.mem_addr !== 8'd2 || bus.mem_wdata !== CW_A) begin
            n_fail++;
            $display("FAIL stall_stable[%0d]: req=%0b we=%0b addr=%0d data=%0h, expected 1 1 2 %0h",
                     i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, CW_A);
         end
         tick();
      end
      gnt_en = 1'b1;
      tick();
      n_checks++;
      if (bus.mem_req !== 1'b0 || wr_addr_q.size() !== 1) begin
         n_fail++;
         $display("FAIL stall_req_drop: req=%0b writes=%0d, expected 0 and 1", bus.mem_req, wr_addr_q.size());
      end
      tick();
      n_checks++;
      if (busy !== 1'b0 || bus.mem_addr !== 8'd3 || mem[2] !== CW_A) begin
         n_fail++;
         $display("FAIL stall_exit_idle: busy=%0b addr=%0d mem2=%0h, expected 0 3 %0h",
                  busy, bus.mem_addr, mem[2], CW_A);
      end
      repeat (5) tick();
      n_checks++;
      if (busy !== 1'b0 || rd_addr_q.size() !== 3) begin
         n_fail++;
         $display("FAIL stall_stays_idle: busy=%0b reads=%0d, expected 0 and 3", busy, rd_addr_q.size());
      end
   endtask

   task automatic test_saturate();
      bit ok;
      apply_reset();
      mem[0] = CW_A_B5;
      mem[1] = CW_B_B1;
      mem[2] = CW_A_B5;
      mem[3] = CW_1_B10;
      force dut.corr_count = 16'hFFFC;
      #1;
      release dut.corr_count;
      enable = 1'b1;
      wait_writes(2, 200, ok);
      n_checks++;
      if (!ok || corr_count !== 16'hFFFE || wr_data_q[1] !== CW_B) begin
         n_fail++;
         $display("FAIL sat_preload: ok=%0d corr=%0h data=%0h, expected FFFE and %0h",
                  ok, corr_count, ok ? wr_data_q[1] : 16'hxxxx, CW_B);
      end
      wait_writes(4, 200, ok);
      n_checks++;
      if (!ok || corr_count !== 16'hFFFF || wr_data_q[3] !== CW_ONES) begin
         n_fail++;
         $display("FAIL sat_hold: ok=%0d corr=%0h data=%0h, expected FFFF and %0h",
                  ok, corr_count, ok ? wr_data_q[3] : 16'hxxxx, CW_ONES);
      end
      stop_scrub();
   endtask

   task automatic test_clr_same_cycle();
      bit ok;
      apply_reset();
      mem[0] = CW_A_B5;
      mem[1] = CW_B_B3B9;
      enable = 1'b1;
      wait_reads(2, 200, ok);
      n_checks++;
      if (!ok || corr_count !== 16'd1) begin
         n_fail++;
         $display("FAIL clr_precount: ok=%0d corr=%0d, expected 1", ok, corr_count);
      end
      tick();
      clr_counts = 1'b1;
      tick();
      clr_counts = 1'b0;
      n_checks++;
      if (corr_count !== 16'd0 || uncorr_count !== 16'd0 || last_uncorr_addr !== 8'd1 || uncorr_irq !== 1'b1) begin
         n_fail++;
         $display("FAIL clr_wins: corr=%0d uncorr=%0d last=%0d irq=%0b, expected 0 0 1 1",
                  corr_count, uncorr_count, last_uncorr_addr, uncorr_irq);
      end
      stop_scrub();
   endtask

   task automatic test_reset_midop();
      bit ok;
      int k;
      apply_reset();
      enable = 1'b1;
      wait_reads(2, 200, ok);
      gnt_en = 1'b0;
      for (k = 0; k < 20 && !(bus.mem_req && bus.mem_addr == 8'd2); k++) tick();
      n_checks++;
      if (!ok || bus.mem_req !== 1'b1 || bus.mem_addr !== 8'd2) begin
         n_fail++;
         $display("FAIL rst_reach_rd: ok=%0d req=%0b addr=%0d, expected read request at 2",
                  ok, bus.mem_req, bus.mem_addr);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.mem_req !== 1'b0 || busy !== 1'b0 || bus.mem_addr !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_async: req=%0b busy=%0b addr=%0d, expected 0 0 0", bus.mem_req, busy, bus.mem_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      gnt_en = 1'b1;
      clear_logs();
      wait_reads(1, 100, ok);
      n_checks++;
      if (!ok || rd_addr_q[0] !== 8'd0) begin
         n_fail++;
         $display("FAIL rst_restart_addr: ok=%0d addr=%0d, expected 0", ok, ok ? rd_addr_q[0] : 8'hxx);
      end
      stop_scrub();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      clear_logs();
      test_reset();
      test_clean_pass();
      test_correct();
      test_uncorrectable();
      test_bit16_only();
      test_stall_write();
      test_saturate();
      test_clr_same_cycle();
      test_reset_midop();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
